updown_mod_counter: RTL and testbench

//  Parametrised synchronous up/down counter with programmable modulus, parallel load,

---
 rtl/updown_mod_counter_pkg.sv | 19 +
 rtl/updown_mod_next.sv | 55 +++++
 rtl/updown_mod_counter.sv | 99 +++++++++
 tb/tb_updown_mod_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared mode/direction constants and parameter sanity helper for the
// up/down modulus counter family.
package updown_mod_counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;
    localparam bit CNT_UP   = 1'b1;
    localparam bit CNT_DN   = 1'b0;

    // Legal when 2 <= modulo <= 2**width and reset_val < modulo.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned modulo,
                                     input int unsigned reset_val);
        longint unsigned span;
        span = 64'd1 << width;
        return (modulo >= 2) && (64'(modulo) <= span) && (reset_val < modulo);
    endfunction

endpackage

// File: rtl/updown_mod_next.sv
// Combinational next-count and wrap/saturate flag logic for one counter step.
module updown_mod_next
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULO   = 256,
    parameter bit          SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_n_o,
    output logic             sat_n_o
);

    localparam int unsigned     EXT_W   = WIDTH + 1;
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULO);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);

    logic [EXT_W-1:0] sum_ext;
    logic [EXT_W-1:0] dif_ext;

    // One extra bit lets MODULO == 2**WIDTH hit the range end like any other modulus.
    always_comb begin
        sum_ext  = {1'b0, count_i} + EXT_W'(1);
        dif_ext  = {1'b0, count_i} - EXT_W'(1);
        next_o   = count_i;
        wrap_n_o = 1'b0;
        sat_n_o  = 1'b0;
        if (up_dn_i == CNT_UP) begin
            if (sum_ext == MOD_EXT) begin
                if (SATURATE == CNT_SAT) begin
                    sat_n_o = 1'b1;
                end else begin
                    next_o   = '0;
                    wrap_n_o = 1'b1;
                end
            end else begin
                next_o = sum_ext[WIDTH-1:0];
            end
        end else begin
            if (dif_ext[EXT_W-1]) begin
                if (SATURATE == CNT_SAT) begin
                    sat_n_o = 1'b1;
                end else begin
                    next_o   = MAX_V;
                    wrap_n_o = 1'b1;
                end
            end else begin
                next_o = dif_ext[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus, parallel load, enable and
// wrap/saturate mode; tc is the zero-latency cascade carry/borrow.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MODULO    = 256,
    parameter bit          SATURATE  = CNT_WRAP,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat,
    output logic             load_err
);

    localparam int unsigned      EXT_W   = WIDTH + 1;
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULO);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

    if (!params_ok(WIDTH, MODULO, RESET_VAL)) begin : g_bad_params
        $error("updown_mod_counter: need 2 <= MODULO <= 2**WIDTH and RESET_VAL < MODULO");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] step_next;
    logic             step_wrap;
    logic             step_sat;
    logic             load_ok;
    logic [WIDTH-1:0] load_eff;
    logic             load_at_end;

    updown_mod_next #(
        .WIDTH    (WIDTH),
        .MODULO   (MODULO),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i  (count_q),
        .up_dn_i  (up_dn),
        .next_o   (step_next),
        .wrap_n_o (step_wrap),
        .sat_n_o  (step_sat)
    );

    // Priority mux: load beats en; out-of-range loads clamp to the top of the range.
    always_comb begin
        load_ok     = ({1'b0, load_val} < MOD_EXT);
        load_eff    = load_ok ? load_val : MAX_V;
        load_at_end = (up_dn == CNT_UP) ? (load_eff == MAX_V) : (load_eff == '0);
        count_d     = count_q;
        wrap_d      = 1'b0;
        sat_d       = sat_q;
        load_err_d  = 1'b0;
        if (load) begin
            count_d    = load_eff;
            load_err_d = ~load_ok;
            sat_d      = (SATURATE == CNT_SAT) && load_at_end;
        end else if (en) begin
            count_d = step_next;
            wrap_d  = step_wrap;
            sat_d   = step_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= RST_V;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc = en & (((up_dn == CNT_UP) & (count_q == MAX_V)) |
                      ((up_dn == CNT_DN) & (count_q == '0)));

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign sat      = sat_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: vector tables for wrap/saturate/full-range
// instances plus a two-stage BCD cascade sequence.
module tb_updown_mod_counter;
    import updown_mod_counter_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        int           sel;
        logic         rst, en, up, ld;
        logic [W-1:0] lv;
        logic [W-1:0] e_cnt;
        logic         e_wrap, e_sat, e_lerr, e_tc;
    } vec_t;

    typedef struct {
        int           sel;
        int           idx;
        logic [W-1:0] cnt;
        logic         wrap, sat, lerr;
    } exp_t;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    exp_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_v[3], en_v[3], up_v[3], ld_v[3];
    logic [W-1:0] lv_v[3];
    logic [W-1:0] cnt_v[3];
    logic         tc_v[3], wrap_v[3], sat_v[3], lerr_v[3];

    // 0: modulo 10 wrap, 1: modulo 10 saturate, 2: modulo 16 wrap with RESET_VAL=3
    updown_mod_counter #(.WIDTH(W), .MODULO(10), .SATURATE(CNT_WRAP), .RESET_VAL(0)) u_wrap (
        .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .up_dn(up_v[0]), .load(ld_v[0]),
        .load_val(lv_v[0]), .count(cnt_v[0]), .tc(tc_v[0]), .wrap(wrap_v[0]),
        .sat(sat_v[0]), .load_err(lerr_v[0]));

    updown_mod_counter #(.WIDTH(W), .MODULO(10), .SATURATE(CNT_SAT), .RESET_VAL(0)) u_sat (
        .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .up_dn(up_v[1]), .load(ld_v[1]),
        .load_val(lv_v[1]), .count(cnt_v[1]), .tc(tc_v[1]), .wrap(wrap_v[1]),
        .sat(sat_v[1]), .load_err(lerr_v[1]));

    updown_mod_counter #(.WIDTH(W), .MODULO(16), .SATURATE(CNT_WRAP), .RESET_VAL(3)) u_full (
        .clk(clk), .reset(rst_v[2]), .en(en_v[2]), .up_dn(up_v[2]), .load(ld_v[2]),
        .load_val(lv_v[2]), .count(cnt_v[2]), .tc(tc_v[2]), .wrap(wrap_v[2]),
        .sat(sat_v[2]), .load_err(lerr_v[2]));

    logic         cs_rst, cs_en;
    logic [W-1:0] cs_cnt0, cs_cnt1;
    logic         cs_tc0, cs_tc1, cs_w0, cs_w1, cs_s0, cs_s1, cs_e0, cs_e1;

    updown_mod_counter #(.WIDTH(W), .MODULO(10), .SATURATE(CNT_WRAP), .RESET_VAL(0)) u_cas0 (
        .clk(clk), .reset(cs_rst), .en(cs_en), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .count(cs_cnt0), .tc(cs_tc0), .wrap(cs_w0),
        .sat(cs_s0), .load_err(cs_e0));

    updown_mod_counter #(.WIDTH(W), .MODULO(10), .SATURATE(CNT_WRAP), .RESET_VAL(0)) u_cas1 (
        .clk(clk), .reset(cs_rst), .en(cs_tc0), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .count(cs_cnt1), .tc(cs_tc1), .wrap(cs_w1),
        .sat(cs_s1), .load_err(cs_e1));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int sel, input logic rst, input logic en, input logic up,
                       input logic ld, input int lv, input int ecnt, input logic ew,
                       input logic es, input logic el, input logic et);
        vec_t v;
        v.sel = sel; v.rst = rst; v.en = en; v.up = up; v.ld = ld;
        v.lv = W'(lv); v.e_cnt = W'(ecnt);
        v.e_wrap = ew; v.e_sat = es; v.e_lerr = el; v.e_tc = et;
        vecs.push_back(v);
    endtask

    // Drive one vector, check tc before the edge, score registered outputs after it.
    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_v[v.sel] = v.rst;
        en_v[v.sel]  = v.en;
        up_v[v.sel]  = v.up;
        ld_v[v.sel]  = v.ld;
        lv_v[v.sel]  = v.lv;
        #1;
        check($sformatf("v%0d_s%0d_tc", idx, v.sel), int'(tc_v[v.sel]), int'(v.e_tc));
        e.sel = v.sel; e.idx = idx; e.cnt = v.e_cnt;
        e.wrap = v.e_wrap; e.sat = v.e_sat; e.lerr = v.e_lerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check($sformatf("v%0d_s%0d_count", got.idx, got.sel), int'(cnt_v[got.sel]), int'(got.cnt));
        check($sformatf("v%0d_s%0d_wrap", got.idx, got.sel), int'(wrap_v[got.sel]), int'(got.wrap));
        check($sformatf("v%0d_s%0d_sat", got.idx, got.sel), int'(sat_v[got.sel]), int'(got.sat));
        check($sformatf("v%0d_s%0d_lerr", got.idx, got.sel), int'(lerr_v[got.sel]), int'(got.lerr));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; en_v[k] = 1'b0; up_v[k] = 1'b1; ld_v[k] = 1'b0; lv_v[k] = '0;
        end
        cs_rst = 1'b1;
        cs_en  = 1'b0;

        // Wrap instance: reset, full up lap, down wrap, loads, reset override, direction flips
        add(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 7,   0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 1, 1, 0, 0, (i + 1) % 10, i == 9, 0, 0, i == 9);
        add(0, 0, 1, 0, 0, 0,   9, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0,   8, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   8, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 5,   5, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 7,   7, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 12,  9, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,   9, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 3,   3, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 10,  9, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 15,  9, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 9,   9, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 6,   6, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 3,   0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   9, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 1);

        // Saturating instance: hold at both ends, release, load-driven sat
        add(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 1);
        add(1, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0);
        for (int i = 1; i < 9; i++)
            add(1, 0, 1, 1, 0, 0, i + 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0,   9, 0, 1, 0, 1);
        add(1, 0, 1, 1, 0, 0,   9, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 0,   9, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0,   8, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 9,   9, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 4,   4, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 12,  9, 0, 1, 1, 0);
        add(1, 0, 1, 0, 1, 9,   9, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 5,   0, 0, 0, 0, 1);

        // Full-range instance: natural overflow both ways, nonzero reset value
        add(2, 1, 0, 1, 0, 0,   3, 0, 0, 0, 0);
        add(2, 0, 0, 1, 1, 15, 15, 0, 0, 0, 0);
        add(2, 0, 1, 1, 0, 0,   0, 1, 0, 0, 1);
        add(2, 0, 1, 0, 0, 0,  15, 1, 0, 0, 1);
        add(2, 0, 1, 0, 0, 0,  14, 0, 0, 0, 0);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Cascade: two modulo-10 stages form a BCD 00..99 counter
        @(negedge clk);
        cs_rst = 1'b1;
        cs_en  = 1'b0;
        @(posedge clk);
        #1;
        check("cas_reset", int'(cs_cnt1) * 10 + int'(cs_cnt0), 0);
        @(negedge clk);
        cs_rst = 1'b0;
        cs_en  = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            check($sformatf("cas_tc1_%0d", i), int'(cs_tc1), int'((i - 1) == 99));
            @(posedge clk);
            #1;
            check($sformatf("cas_bcd_%0d", i), int'(cs_cnt1) * 10 + int'(cs_cnt0), i % 100);
            check($sformatf("cas_wrap0_%0d", i), int'(cs_w0), int'((i % 10) == 0));
            check($sformatf("cas_wrap1_%0d", i), int'(cs_w1), int'((i % 100) == 0));
        end
        check("cas_sat", int'(cs_s0 | cs_s1 | cs_e0 | cs_e1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
